downlink_frame_parser: RTL and testbench
========================================

DOWNLINK_FRAME_PARSER -- requirements
Module: downlink_frame_parser

Interface
REQ-001 SHALL have parameter PREAMBLE_W, default 8, preamble length in bits.
REQ-002 SHALL have parameter PREAMBLE, default 8'b11011101, sync word compared MSB-first.
REQ-003 SHALL have parameter PAYLOAD_W, default 7 (min 7), payload length in bits.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 16 (min 2), max idle clocks between bits inside a frame.
REQ-005 SHALL have port clock  input  1  block clock, single clock domain.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port write_en  input  1  one-cycle strobe, downlink_bit valid this cycle.
REQ-008 SHALL have port downlink_bit  input  1  decoded downlink data bit.
REQ-009 SHALL have port resolution  output  1  0=low, 1=high; payload bit PAYLOAD_W-1.
REQ-010 SHALL have port compression  output  3  payload bits PAYLOAD_W-2..PAYLOAD_W-4.
REQ-011 SHALL have port repetition  output  3  payload bits PAYLOAD_W-5..PAYLOAD_W-7.
REQ-012 SHALL have port payload  output  PAYLOAD_W  last accepted payload, full width, reserved low bits included.
REQ-013 SHALL have port frame_valid  output  1  one-cycle pulse on accepted frame.
REQ-014 SHALL have port frame_error  output  1  one-cycle pulse on parity fail or timeout.
REQ-015 SHALL have port busy  output  1  high when state is not HUNT.

Function
REQ-016 SHALL implement states HUNT, PAYLOAD, PARITY; all logic on rising edge of clock; bits consumed only in cycles with write_en=1.
REQ-017 In HUNT, each bit SHALL shift into a PREAMBLE_W-bit register (LSB = newest); when the shifted-in value equals PREAMBLE, next state SHALL be PAYLOAD with bit count 0; overlapping preambles SHALL be detected.
REQ-018 In PAYLOAD, bits SHALL be stored MSB-first; after the PAYLOAD_W-th bit, next state SHALL be PARITY.
REQ-019 In PARITY, the next bit SHALL be an even-parity bit: XOR of all payload bits and parity bit equal to 0 passes.
REQ-020 On pass, resolution, compression, repetition, payload SHALL update and frame_valid SHALL be 1 in the cycle after the parity bit is sampled (latency 1 clock).
REQ-021 On fail, frame_error SHALL pulse with same latency; all field outputs SHALL hold previous values.
REQ-022 After PARITY (pass or fail), state SHALL return to HUNT with the preamble register cleared to 0; a full new preamble SHALL be required.
REQ-023 In PAYLOAD/PARITY, an idle counter SHALL count clocks without write_en and clear on each write_en; on reaching TIMEOUT_CYC, frame_error SHALL pulse next cycle, state SHALL go to HUNT, preamble register and partial payload SHALL be discarded, field outputs held.
REQ-024 If write_en is high in the cycle the counter would reach TIMEOUT_CYC, the bit SHALL be consumed and no timeout raised.
REQ-025 Idle counter SHALL be held at 0 in HUNT; counter width SHALL be $clog2(TIMEOUT_CYC+1).
REQ-026 frame_valid and frame_error SHALL never be high in the same cycle.

Reset
REQ-027 While reset=1 at a rising edge: state HUNT, preamble register, payload shift, bit and idle counters 0; resolution, compression, repetition, payload, frame_valid, frame_error, busy SHALL be 0 the following cycle.
REQ-028 Reset mid-frame SHALL abort the frame without frame_error; reset SHALL take priority over write_en.

Structure
REQ-029 Package downlink_pkg SHALL hold the state enum, default PREAMBLE, field offsets/widths (RES_W=1, COMP_W=3, REP_W=3).
REQ-030 Preamble matching SHALL be a sub-module downlink_sync_detector (shift register plus comparator, parameterised by PREAMBLE_W/PREAMBLE, with clear input).

Verification
REQ-031 Defaults; bits 11011101, 1010011, parity 0 -> one cycle later resolution=1, compression=010, repetition=011, frame_valid=1 for one cycle.
REQ-032 Same frame with parity 1 -> frame_error=1 one cycle, outputs stay at reset/previous values, busy=0.
REQ-033 Preamble then 3 payload bits, then 16 idle clocks -> frame_error pulse, busy falls; following valid frame 11011101,0000000,0 -> all fields 0, frame_valid=1.
REQ-034 Leading noise 111011101 then payload 0111111, parity 0 -> overlapping preamble found, compression=111, repetition=111, resolution=0.
REQ-035 reset=1 after 4 payload bits -> no frame_error, busy=0, outputs 0; next full frame decodes normally.
REQ-036 write_en held every cycle vs. spaced 15 clocks apart -> identical outputs, no timeout.

Source files
------------

// File: rtl/downlink_pkg.sv
// rtl/downlink_pkg.sv - shared types and field layout for the downlink frame parser
package downlink_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        PARITY  = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_PREAMBLE = 8'b11011101;

    localparam int RES_W  = 1;
    localparam int COMP_W = 3;
    localparam int REP_W  = 3;

    // Offsets count down from the payload MSB: field top bit = PAYLOAD_W - *_OFS.
    localparam int RES_OFS  = 1;
    localparam int COMP_OFS = RES_OFS + RES_W;
    localparam int REP_OFS  = COMP_OFS + COMP_W;

endpackage

// File: rtl/downlink_sync_detector.sv
// rtl/downlink_sync_detector.sv - serial preamble shift register and comparator
module downlink_sync_detector #(
    parameter int                    PREAMBLE_W = 8,
    parameter logic [PREAMBLE_W-1:0] PREAMBLE   = 8'b11011101
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic shift_en,
    input  logic bit_in,
    output logic match
);

    logic [PREAMBLE_W-1:0] sync_q;
    logic [PREAMBLE_W-1:0] shifted;

    // Compare against the value being shifted in so a match is reported in the same cycle.
    assign shifted = {sync_q[PREAMBLE_W-2:0], bit_in};
    assign match   = shift_en && (shifted == PREAMBLE);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            sync_q <= '0;
        end else if (shift_en) begin
            sync_q <= shifted;
        end
    end

endmodule

// File: rtl/downlink_frame_parser.sv
// rtl/downlink_frame_parser.sv - preamble hunt, payload capture and even-parity check
module downlink_frame_parser
    import downlink_pkg::*;
#(
    parameter int                    PREAMBLE_W  = 8,
    parameter logic [PREAMBLE_W-1:0] PREAMBLE    = DEFAULT_PREAMBLE,
    parameter int                    PAYLOAD_W   = 7,
    parameter int                    TIMEOUT_CYC = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 write_en,
    input  logic                 downlink_bit,
    output logic                 resolution,
    output logic [COMP_W-1:0]    compression,
    output logic [REP_W-1:0]     repetition,
    output logic [PAYLOAD_W-1:0] payload,
    output logic                 frame_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam int BIT_W = $clog2(PAYLOAD_W + 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(PAYLOAD_W - 1);

    state_t               state_q, state_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]     idle_q, idle_d;
    logic [PAYLOAD_W-1:0] shift_q, shift_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 valid_q, valid_d;
    logic                 error_q, error_d;
    logic                 sync_clear;
    logic                 sync_match;
    logic                 idle_expire;

    downlink_sync_detector #(
        .PREAMBLE_W (PREAMBLE_W),
        .PREAMBLE   (PREAMBLE)
    ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .clear    (sync_clear),
        .shift_en (write_en && (state_q == HUNT)),
        .bit_in   (downlink_bit),
        .match    (sync_match)
    );

    // A bit arriving on the cycle the counter would hit the limit still counts.
    assign idle_expire = !write_en && (idle_q == IDLE_LAST);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        idle_d     = idle_q;
        shift_d    = shift_q;
        payload_d  = payload_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        sync_clear = 1'b0;

        case (state_q)
            HUNT: begin
                idle_d = '0;
                if (sync_match) begin
                    state_d   = PAYLOAD;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            PAYLOAD: begin
                if (write_en) begin
                    idle_d  = '0;
                    shift_d = {shift_q[PAYLOAD_W-2:0], downlink_bit};
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else if (idle_expire) begin
                    state_d    = HUNT;
                    error_d    = 1'b1;
                    sync_clear = 1'b1;
                    idle_d     = '0;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                end else begin
                    idle_d = idle_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (write_en) begin
                    state_d    = HUNT;
                    sync_clear = 1'b1;
                    idle_d     = '0;
                    bit_cnt_d  = '0;
                    if ((^shift_q ^ downlink_bit) == 1'b0) begin
                        payload_d = shift_q;
                        valid_d   = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (idle_expire) begin
                    state_d    = HUNT;
                    error_d    = 1'b1;
                    sync_clear = 1'b1;
                    idle_d     = '0;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                end else begin
                    idle_d = idle_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = HUNT;
                sync_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= HUNT;
            bit_cnt_q <= '0;
            idle_q    <= '0;
            shift_q   <= '0;
            payload_q <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idle_q    <= idle_d;
            shift_q   <= shift_d;
            payload_q <= payload_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    assign resolution  = payload_q[PAYLOAD_W-RES_OFS];
    assign compression = payload_q[PAYLOAD_W-COMP_OFS -: COMP_W];
    assign repetition  = payload_q[PAYLOAD_W-REP_OFS -: REP_W];
    assign payload     = payload_q;
    assign frame_valid = valid_q;
    assign frame_error = error_q;
    assign busy        = (state_q != HUNT);

endmodule

// File: tb/tb_downlink_frame_parser.sv
// tb/tb_downlink_frame_parser.sv - scoreboard bench for downlink_frame_parser
module tb_downlink_frame_parser;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       write_en = 1'b0;
    logic       downlink_bit = 1'b0;
    logic       resolution;
    logic [2:0] compression;
    logic [2:0] repetition;
    logic [6:0] payload;
    logic       frame_valid;
    logic       frame_error;
    logic       busy;

    downlink_frame_parser dut (
        .clock        (clock),
        .reset        (reset),
        .write_en     (write_en),
        .downlink_bit (downlink_bit),
        .resolution   (resolution),
        .compression  (compression),
        .repetition   (repetition),
        .payload      (payload),
        .frame_valid  (frame_valid),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         is_err;
        logic [6:0] pay;
        logic       res;
        logic [2:0] comp;
        logic [2:0] rep;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit is_err, input logic [6:0] pay, input logic res,
                            input logic [2:0] comp, input logic [2:0] rep);
        exp_t e;
        e.is_err = is_err;
        e.pay    = pay;
        e.res    = res;
        e.comp   = comp;
        e.rep    = rep;
        e.cyc    = cyc;
        q.push_back(e);
    endtask

    // Monitor: pops one expectation per output pulse
    always @(negedge clock) begin
        if (frame_valid || frame_error) begin
            chk("valid_error_exclusive", 32'(frame_valid & frame_error), 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_pulse", 32'(frame_error), 32'(frame_valid) + 32'd2);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_kind_error", 32'(frame_error), 32'(e.is_err));
                chk("pulse_kind_valid", 32'(frame_valid), 32'(!e.is_err));
                chk("pulse_latency", 32'(cyc), 32'(e.cyc));
                chk("payload", 32'(payload), 32'(e.pay));
                chk("resolution", 32'(resolution), 32'(e.res));
                chk("compression", 32'(compression), 32'(e.comp));
                chk("repetition", 32'(repetition), 32'(e.rep));
                chk("busy_after_frame", 32'(busy), 32'd0);
            end
        end
    end

    task automatic idle(input int n);
        write_en = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        write_en     = 1'b1;
        downlink_bit = b;
        @(posedge clock);
        #1;
        write_en = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            idle(gap);
            send_bit(v[i]);
        end
    endtask

    task automatic check_fields(input string tag, input logic [6:0] pay, input logic b);
        chk({tag, "_payload"}, 32'(payload), 32'(pay));
        chk({tag, "_busy"}, 32'(busy), 32'(b));
    endtask

    localparam logic [7:0] PRE = 8'b11011101;

    initial begin
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(1);
        chk("rst_resolution", 32'(resolution), 32'd0);
        chk("rst_compression", 32'(compression), 32'd0);
        chk("rst_repetition", 32'(repetition), 32'd0);
        chk("rst_payload", 32'(payload), 32'd0);
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        chk("rst_frame_error", 32'(frame_error), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Good frame: 1010011, even parity 0
        send_bits(32'(PRE), 8, 0);
        chk("busy_after_preamble", 32'(busy), 32'd1);
        send_bits(32'b1010011, 7, 0);
        send_bit(1'b0);
        push_exp(1'b0, 7'b1010011, 1'b1, 3'b010, 3'b011);
        idle(2);

        // Same frame, bad parity: fields hold
        send_bits(32'(PRE), 8, 0);
        send_bits(32'b1010011, 7, 0);
        send_bit(1'b1);
        push_exp(1'b1, 7'b1010011, 1'b1, 3'b010, 3'b011);
        idle(2);

        // Timeout after 3 payload bits
        send_bits(32'(PRE), 8, 0);
        send_bits(32'b101, 3, 0);
        idle(15);
        chk("busy_before_timeout", 32'(busy), 32'd1);
        idle(1);
        push_exp(1'b1, 7'b1010011, 1'b1, 3'b010, 3'b011);
        chk("busy_after_timeout", 32'(busy), 32'd0);
        idle(2);
        send_bits(32'(PRE), 8, 0);
        send_bits(32'b0000000, 7, 0);
        send_bit(1'b0);
        push_exp(1'b0, 7'b0000000, 1'b0, 3'b000, 3'b000);
        idle(2);

        // Overlapping preamble behind leading noise
        send_bits(32'b111011101, 9, 0);
        chk("busy_after_noise_preamble", 32'(busy), 32'd1);
        send_bits(32'b0111111, 7, 0);
        send_bit(1'b0);
        push_exp(1'b0, 7'b0111111, 1'b0, 3'b111, 3'b111);
        idle(2);

        // Reset mid-frame: no error, outputs cleared
        send_bits(32'(PRE), 8, 0);
        send_bits(32'b1010, 4, 0);
        reset = 1'b1;
        send_bit(1'b1);
        reset = 1'b0;
        check_fields("mid_reset", 7'b0000000, 1'b0);
        chk("mid_reset_resolution", 32'(resolution), 32'd0);
        idle(20);
        send_bits(32'(PRE), 8, 0);
        send_bits(32'b1010011, 7, 0);
        send_bit(1'b0);
        push_exp(1'b0, 7'b1010011, 1'b1, 3'b010, 3'b011);
        idle(2);

        // Odd payload weight needs parity 1
        send_bits(32'(PRE), 8, 0);
        send_bits(32'b1110000, 7, 0);
        send_bit(1'b1);
        push_exp(1'b0, 7'b1110000, 1'b1, 3'b110, 3'b000);
        idle(2);

        // Back-to-back bits vs. 15 idle clocks between bits
        send_bits(32'(PRE), 8, 0);
        send_bits(32'b1100110, 7, 0);
        send_bit(1'b0);
        push_exp(1'b0, 7'b1100110, 1'b1, 3'b100, 3'b110);
        idle(2);
        send_bits(32'b1110000, 7, 0);
        check_fields("stale_bits_ignored", 7'b1100110, 1'b0);
        send_bits(32'(PRE), 8, 15);
        send_bits(32'b1100110, 7, 15);
        idle(15);
        chk("busy_spaced_parity", 32'(busy), 32'd1);
        send_bit(1'b0);
        push_exp(1'b0, 7'b1100110, 1'b1, 3'b100, 3'b110);
        idle(3);

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
